// File: rtl/sram_loader_pkg.sv
// Shared sizing constants and FSM state encoding for the SRAM weight loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_loader_pkg;

    localparam int DATA_W     = 8;
    localparam int WORD_BYTES = 9;
    localparam int ADDR_W     = 10;
    localparam int DEPTH      = 576;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/sram_loader_if.sv
// Control, byte-stream and SRAM-write bundle between a byte source and the loader.
// Latency: n/a (wires only).
// Backpressure: byte_ready from the loader throttles byte_valid/byte_data.
interface sram_loader_if #(
    parameter int DATA_W     = sram_loader_pkg::DATA_W,
    parameter int WORD_BYTES = sram_loader_pkg::WORD_BYTES,
    parameter int ADDR_W     = sram_loader_pkg::ADDR_W
);
    logic                         start;
    logic [ADDR_W-1:0]            base_addr;
    logic [ADDR_W-1:0]            word_num;
    logic                         byte_valid;
    logic [DATA_W-1:0]            byte_data;
    logic                         byte_ready;
    logic                         write_en;
    logic [ADDR_W-1:0]            addr_w;
    logic [DATA_W*WORD_BYTES-1:0] data_w;
    logic                         busy;
    logic                         done;
    logic                         err;

    // Byte source / load controller side.
    modport master (
        output start, base_addr, word_num, byte_valid, byte_data,
        input  byte_ready, write_en, addr_w, data_w, busy, done, err
    );

    // Loader side.
    modport slave (
        input  start, base_addr, word_num, byte_valid, byte_data,
        output byte_ready, write_en, addr_w, data_w, busy, done, err
    );
endinterface

// File: rtl/sram_loader_byte_packer.sv
// Packs WORD_BYTES accepted bytes into one word, first byte in the MSB position.
// Latency: combinational word/full view of the byte accepted this cycle.
// Backpressure: none; only advances on accept, caller owns the handshake.
module sram_loader_byte_packer #(
    parameter int DATA_W     = sram_loader_pkg::DATA_W,
    parameter int WORD_BYTES = sram_loader_pkg::WORD_BYTES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         accept,
    input  logic [DATA_W-1:0]            byte_data,
    output logic                         word_full,
    output logic [DATA_W*WORD_BYTES-1:0] pack_word
);
    localparam int WORD_W = DATA_W * WORD_BYTES;
    localparam int CNT_W  = $clog2(WORD_BYTES);

    // Only the first WORD_BYTES-1 bytes need storage; the last byte is taken
    // straight from the input in the cycle it is accepted.
    logic [WORD_W-DATA_W-1:0] shreg;
    logic [CNT_W-1:0]         cnt;

    assign pack_word = {shreg, byte_data};
    assign word_full = accept && (cnt == CNT_W'(WORD_BYTES - 1));

    // Shift accepted bytes toward the MSB end and count them per word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (accept) begin
            shreg <= {shreg[WORD_W-2*DATA_W-1:0], byte_data};
            cnt   <= word_full ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sram_loader.sv
// Loads word_num packed words from a byte stream into SRAM starting at base_addr.
// Latency: write_en one cycle after the last byte of a word; done one cycle after the last write.
// Backpressure: byte_ready only in FILL; bytes offered in any other state are ignored.
module sram_loader #(
    parameter int DATA_W     = sram_loader_pkg::DATA_W,
    parameter int WORD_BYTES = sram_loader_pkg::WORD_BYTES,
    parameter int ADDR_W     = sram_loader_pkg::ADDR_W,
    parameter int DEPTH      = sram_loader_pkg::DEPTH
) (
    input  logic           clk,
    input  logic           rst_n,
    sram_loader_if.slave   bus
);
    import sram_loader_pkg::*;

    localparam int              WORD_W  = DATA_W * WORD_BYTES;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   num_q;
    logic [ADDR_W-1:0]   word_idx;
    logic                ready_q;
    logic                write_en_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   data_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                accept;
    logic                start_ok;
    logic                word_full;
    logic [WORD_W-1:0]   pack_word;
    logic [ADDR_W:0]     end_addr;
    logic [ADDR_W-1:0]   word_nxt;

    assign accept   = bus.byte_valid && ready_q;
    assign start_ok = (state == ST_IDLE) && bus.start;
    // One bit wider than the address so a load ending past the top cannot wrap.
    assign end_addr = {1'b0, bus.base_addr} + {1'b0, bus.word_num};
    assign word_nxt = word_idx + 1'b1;

    sram_loader_byte_packer #(
        .DATA_W     (DATA_W),
        .WORD_BYTES (WORD_BYTES)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_ok),
        .accept     (accept),
        .byte_data  (bus.byte_data),
        .word_full  (word_full),
        .pack_word  (pack_word)
    );

    // Load sequencer; every output is registered and set on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            word_idx   <= '0;
            ready_q    <= 1'b0;
            write_en_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            write_en_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        base_q   <= bus.base_addr;
                        num_q    <= bus.word_num;
                        word_idx <= '0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        if (bus.word_num == '0) begin
                            state  <= ST_FIN;
                            done_q <= 1'b1;
                        end else if (end_addr > DEPTH_L) begin
                            err_q  <= 1'b1;
                            state  <= ST_FIN;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ST_FILL;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (word_full) begin
                        state      <= ST_WRITE;
                        ready_q    <= 1'b0;
                        write_en_q <= 1'b1;
                        addr_q     <= base_q + word_idx;
                        data_q     <= pack_word;
                    end
                end
                ST_WRITE: begin
                    word_idx <= word_nxt;
                    if (word_nxt == num_q) begin
                        state  <= ST_FIN;
                        done_q <= 1'b1;
                    end else begin
                        state   <= ST_FILL;
                        ready_q <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.write_en   = write_en_q;
    assign bus.addr_w     = addr_q;
    assign bus.data_w     = data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_sram_loader.sv
// Directed bench for sram_loader: packing, addressing, range errors, start/reset corner cases.
// Latency: checks write_en one cycle after the ninth byte and done after the last write.
// Backpressure: byte source waits on byte_ready with a bounded cycle budget.
module tb_sram_loader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_loader_if bus ();

    sram_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [9:0]  wr_addr_q[$];
    logic [71:0] wr_data_q[$];
    int          done_cnt     = 0;
    int          rdy_in_write = 0;

    // Observe the SRAM-side outputs mid-cycle.
    always @(negedge clk) begin
        if (bus.write_en) begin
            wr_addr_q.push_back(bus.addr_w);
            wr_data_q.push_back(bus.data_w);
            if (bus.byte_ready) rdy_in_write++;
        end
        if (bus.done) done_cnt++;
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [9:0] base, input logic [9:0] num);
        bus.byte_valid = 1'b0;
        bus.base_addr  = base;
        bus.word_num   = num;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    // Offer one byte after an optional idle gap; leaves byte_valid high.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        int   guard;
        repeat (gap) begin
            bus.byte_valid = 1'b0;
            tick();
        end
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        guard = 0;
        do begin
            r = bus.byte_ready;
            tick();
            guard++;
        end while (!r && guard < 40);
        if (!r) check("byte_accept_timeout", {71'd0, r}, 72'd1);
    endtask

    task automatic send_range(input logic [7:0] first, input int count, input int max_gap);
        for (int k = 0; k < count; k++)
            send_byte(first + 8'(k), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    // Expected word for nine consecutive byte values starting at 'first', byte 0 in the MSB.
    function automatic logic [71:0] exp_word(input logic [7:0] first);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w = {w[63:0], first + 8'(k)};
        return w;
    endfunction

    task automatic wait_done(input string tag, input int max_cycles);
        int s;
        int g;
        s = done_cnt;
        g = 0;
        while (done_cnt == s && g < max_cycles) begin
            tick();
            g++;
        end
        tick();
        check(tag, 72'(done_cnt - s), 72'd1);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        logic seen_rdy;

        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_num   = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        rst_n          = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_busy",     {71'd0, bus.busy},       72'd0);
        check("rst_done",     {71'd0, bus.done},       72'd0);
        check("rst_err",      {71'd0, bus.err},        72'd0);
        check("rst_write_en", {71'd0, bus.write_en},   72'd0);
        check("rst_ready",    {71'd0, bus.byte_ready}, 72'd0);
        check("rst_addr",     72'(bus.addr_w),         72'd0);
        check("rst_data",     bus.data_w,              72'd0);
        rst_n = 1'b1;
        tick();

        // Single word, byte_valid held high.
        clear_log();
        do_start(10'd0, 10'd1);
        check("t1_busy",  {71'd0, bus.busy},       72'd1);
        check("t1_ready", {71'd0, bus.byte_ready}, 72'd1);
        send_range(8'h01, 9, 0);
        bus.byte_valid = 1'b0;
        check("t1_wen_latency", {71'd0, bus.write_en},   72'd1);
        check("t1_ready_wr",    {71'd0, bus.byte_ready}, 72'd0);
        check("t1_addr",        72'(bus.addr_w),         72'd0);
        check("t1_data",        bus.data_w,              72'h010203040506070809);
        tick();
        check("t1_done",       {71'd0, bus.done},     72'd1);
        check("t1_wen_off",    {71'd0, bus.write_en}, 72'd0);
        tick();
        check("t1_done_pulse", {71'd0, bus.done},     72'd0);
        check("t1_idle_busy",  {71'd0, bus.busy},     72'd0);
        check("t1_data_hold",  bus.data_w,            72'h010203040506070809);
        check("t1_nwrites",    72'(wr_addr_q.size()), 72'd1);

        // Three words with random gaps, plus an ignored second start mid-load.
        clear_log();
        d0 = done_cnt;
        do_start(10'd100, 10'd3);
        send_range(8'h20, 9, 2);
        send_range(8'h29, 4, 2);
        do_start(10'd5, 10'd1);
        send_range(8'h2D, 5, 2);
        send_range(8'h32, 9, 2);
        bus.byte_valid = 1'b0;
        wait_done("t2_done", 40);
        check("t2_nwrites", 72'(wr_addr_q.size()), 72'd3);
        for (int w = 0; w < 3 && w < wr_addr_q.size(); w++) begin
            check($sformatf("t2_addr%0d", w), 72'(wr_addr_q[w]), 72'(100 + w));
            check($sformatf("t2_data%0d", w), wr_data_q[w], exp_word(8'(8'h20 + 9 * w)));
        end
        repeat (3) tick();
        check("t2_done_once",   72'(done_cnt - d0), 72'd1);
        check("t2_rdy_in_wr",   72'(rdy_in_write),  72'd0);
        check("t2_idle_busy",   {71'd0, bus.busy},  72'd0);

        // Range error: 570 + 7 = 577 > 576.
        clear_log();
        do_start(10'd570, 10'd7);
        check("t3_err",  {71'd0, bus.err},  72'd1);
        check("t3_done", {71'd0, bus.done}, 72'd1);
        repeat (4) tick();
        check("t3_err_hold", {71'd0, bus.err},      72'd1);
        check("t3_nwrites",  72'(wr_addr_q.size()), 72'd0);
        check("t3_busy",     {71'd0, bus.busy},     72'd0);

        // Exact fit: 569 + 7 = 576 ends at the last word.
        clear_log();
        do_start(10'd569, 10'd7);
        check("t4_err_clr", {71'd0, bus.err}, 72'd0);
        for (int w = 0; w < 7; w++) send_range(8'(8'h40 + 9 * w), 9, 1);
        bus.byte_valid = 1'b0;
        wait_done("t4_done", 40);
        check("t4_nwrites", 72'(wr_addr_q.size()), 72'd7);
        if (wr_addr_q.size() == 7) begin
            check("t4_first_addr", 72'(wr_addr_q[0]), 72'd569);
            check("t4_last_addr",  72'(wr_addr_q[6]), 72'd575);
            check("t4_last_data",  wr_data_q[6],      exp_word(8'h76));
        end
        check("t4_err", {71'd0, bus.err}, 72'd0);

        // Zero-length load.
        clear_log();
        d0 = done_cnt;
        seen_rdy = 1'b0;
        do_start(10'd3, 10'd0);
        seen_rdy = seen_rdy | bus.byte_ready;
        tick();
        seen_rdy = seen_rdy | bus.byte_ready;
        check("t5_done_2cyc", 72'(done_cnt - d0), 72'd1);
        repeat (3) begin
            tick();
            seen_rdy = seen_rdy | bus.byte_ready;
        end
        check("t5_ready_low", {71'd0, seen_rdy},     72'd0);
        check("t5_nwrites",   72'(wr_addr_q.size()), 72'd0);
        check("t5_done_once", 72'(done_cnt - d0),    72'd1);

        // Reset after 5 bytes of word 2.
        clear_log();
        do_start(10'd200, 10'd3);
        send_range(8'h80, 23, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy",  {71'd0, bus.busy},       72'd0);
        check("t6_rst_ready", {71'd0, bus.byte_ready}, 72'd0);
        check("t6_rst_wen",   {71'd0, bus.write_en},   72'd0);
        check("t6_rst_addr",  72'(bus.addr_w),         72'd0);
        check("t6_rst_data",  bus.data_w,              72'd0);
        check("t6_rst_done",  {71'd0, bus.done},       72'd0);
        tick();
        rst_n = 1'b1;
        clear_log();
        d0 = done_cnt;
        repeat (12) tick();
        check("t6_no_write", 72'(wr_addr_q.size()), 72'd0);
        check("t6_no_done",  72'(done_cnt - d0),     72'd0);
        bus.byte_valid = 1'b0;
        do_start(10'd10, 10'd2);
        send_range(8'hA0, 18, 1);
        bus.byte_valid = 1'b0;
        wait_done("t6_fresh_done", 40);
        check("t6_fresh_n", 72'(wr_addr_q.size()), 72'd2);
        if (wr_addr_q.size() == 2) begin
            check("t6_fresh_addr0", 72'(wr_addr_q[0]), 72'd10);
            check("t6_fresh_addr1", 72'(wr_addr_q[1]), 72'd11);
            check("t6_fresh_data1", wr_data_q[1],      exp_word(8'hA9));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sram_loader.md
SRAM_LOADER -- requirements
Module: sram_loader

Interface
REQ-001 Parameter DATA_W, default 8: width of one input byte.
REQ-002 Parameter WORD_BYTES, default 9: bytes packed per SRAM word (9x8 = 72 bits).
REQ-003 Parameter ADDR_W, default 10: SRAM address width.
REQ-004 Parameter DEPTH, default 576: number of SRAM words.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse that begins a load.
REQ-008 base_addr  input  ADDR_W  first SRAM word address, sampled on start.
REQ-009 word_num  input  ADDR_W  number of words to load, sampled on start.
REQ-010 byte_valid  input  1  byte_data is valid this cycle.
REQ-011 byte_data  input  DATA_W  incoming weight/bias byte.
REQ-012 byte_ready  output  1  loader accepts a byte this cycle.
REQ-013 write_en  output  1  SRAM write strobe, drives the top-level write_en.
REQ-014 addr_w  output  ADDR_W  SRAM write address.
REQ-015 data_w  output  DATA_W*WORD_BYTES  SRAM write data.
REQ-016 busy  output  1  a load is in progress.
REQ-017 done  output  1  one-cycle end-of-load pulse.
REQ-018 err  output  1  range error on the last start.

Function
REQ-019 A byte transfer SHALL occur only in a cycle where byte_valid and byte_ready are both 1.
REQ-020 FSM states SHALL be IDLE, FILL, WRITE and FIN.
REQ-021 IDLE: byte_ready=0 and busy=0; start SHALL latch base_addr and word_num and clear err.
- word_num=0 -> FIN, no write.
- base_addr+word_num>DEPTH (sum computed ADDR_W+1 bits wide) -> set err, go to FIN, no write.
- otherwise -> FILL, word index=0, byte count=0.
REQ-022 FILL: byte_ready=1. The k-th accepted byte (k=0..8) SHALL be stored at data bits [8*(8-k)+7 : 8*(8-k)], so byte 0 lands in the MSB byte. Acceptance of byte 8 -> WRITE.
REQ-023 WRITE: lasts exactly one cycle.
- write_en=1, byte_ready=0, addr_w=base_addr+word index, data_w=packed word.
- Then increment the word index; if it equals word_num -> FIN, else -> FILL with byte count=0.
REQ-024 FIN: done=1 for exactly one cycle, then -> IDLE; busy SHALL be 1 in FILL, WRITE and FIN.
REQ-025 Latency: byte 8 accepted at cycle N -> write_en=1 at cycle N+1; peak throughput one word per 10 cycles.
REQ-026 start while busy=1 SHALL be ignored; byte_valid in IDLE, WRITE or FIN SHALL be ignored.
REQ-027 addr_w and data_w SHALL be registered and hold their last values while write_en=0.
REQ-028 write_en SHALL never be 1 outside WRITE; the last address written SHALL never exceed DEPTH-1.
REQ-029 err SHALL hold until the next accepted start.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE and set every output, counter and data register to 0.
REQ-031 Reset during FILL or WRITE SHALL abort the load: no write, and no done pulse after release.

Structure
REQ-032 A shared package SHALL hold DATA_W, WORD_BYTES, ADDR_W, DEPTH and the FSM state enumeration.
REQ-033 One sub-module, byte_packer (shift/pack register plus byte counter with a full flag), is natural; the FSM and address counter stay in sram_loader.

Verification
REQ-034 start, base_addr=0, word_num=1, bytes 0x01..0x09 with byte_valid held high -> one write_en pulse, addr_w=0, data_w=0x010203040506070809, done one cycle later.
REQ-035 base_addr=100, word_num=3, 27 bytes with random byte_valid gaps -> writes at addresses 100, 101, 102 only, correct packing, done once, byte_ready=0 in every WRITE cycle.
REQ-036 base_addr=570, word_num=7 -> err=1, done pulse, no write_en; base_addr=569, word_num=7 -> 7 writes ending at address 575, err=0.
REQ-037 word_num=0 -> done pulse two cycles after start, no write_en, byte_ready stays 0.
REQ-038 Second start during a load -> ignored, original address sequence intact.
REQ-039 rst_n pulsed low after 5 bytes of word 2 -> all outputs 0 at once; after release no write and no done; a fresh load then completes correctly.
